// File: rtl/ram_log_reader_if.sv
// Bundle of control, RAM read-port and stream signals for ram_log_reader.
// The master modport is the reader; slave is the surrounding system.
interface ram_log_reader_if #(
  parameter int RAM_WIDTH = 32,
  parameter int RAM_DEPTH = 32768
);
  localparam int ADDR_W = $clog2(RAM_DEPTH);

  logic                 i_start;
  logic [ADDR_W-1:0]    i_start_adrs;
  logic [ADDR_W:0]      i_num_words;
  logic                 i_abort;
  logic                 o_ram_en_read;
  logic [ADDR_W-1:0]    o_ram_read_adrs;
  logic [RAM_WIDTH-1:0] i_ram_data;
  logic [RAM_WIDTH-1:0] o_data;
  logic                 o_valid;
  logic                 i_ready;
  logic                 o_last;
  logic                 o_busy;
  logic                 o_done;
  logic [ADDR_W:0]      o_words_sent;
  logic [RAM_WIDTH-1:0] o_checksum;

  modport master (
    input  i_start, i_start_adrs, i_num_words, i_abort, i_ram_data, i_ready,
    output o_ram_en_read, o_ram_read_adrs, o_data, o_valid, o_last, o_busy,
           o_done, o_words_sent, o_checksum
  );

  modport slave (
    output i_start, i_start_adrs, i_num_words, i_abort, i_ram_data, i_ready,
    input  o_ram_en_read, o_ram_read_adrs, o_data, o_valid, o_last, o_busy,
           o_done, o_words_sent, o_checksum
  );
endinterface

// File: rtl/ram_log_reader.sv
// Reads a burst of consecutive log RAM words and streams them over valid/ready.
// Optional feature macro: RAM_LOG_READER_CHECKSUM_EN (running sum of accepted words).
module ram_log_reader #(
  parameter int RAM_WIDTH = 32,
  parameter int RAM_DEPTH = 32768
) (
  input  logic               clk,
  input  logic               i_reset,
  ram_log_reader_if.master   bus
);
  localparam int ADDR_W = $clog2(RAM_DEPTH);
  localparam logic [ADDR_W:0]   NUM_MAX   = (ADDR_W+1)'(RAM_DEPTH);
  localparam logic [ADDR_W:0]   NUM_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   NUM_ZERO  = '0;
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(RAM_DEPTH-1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  typedef enum logic [2:0] {IDLE, REQ, CAPT, SEND, DONE} state_e;

  state_e               state_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [ADDR_W-1:0]    rd_adrs_q;
  logic [ADDR_W:0]      remaining_q;
  logic [ADDR_W:0]      words_q;
  logic [RAM_WIDTH-1:0] data_q;
  logic                 en_q;
  logic                 valid_q;
  logic                 last_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 start_acc;
  logic                 handshake;
  logic [ADDR_W:0]      num_sat;
  logic [ADDR_W-1:0]    addr_next;

  assign start_acc = (state_q == IDLE) && bus.i_start;
  assign handshake = (state_q == SEND) && valid_q && bus.i_ready && !bus.i_abort;
  assign num_sat   = (bus.i_num_words > NUM_MAX) ? NUM_MAX : bus.i_num_words;
  assign addr_next = (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_ONE;

  // Abort wins over everything except a fresh start taken in IDLE.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rd_adrs_q   <= '0;
      remaining_q <= '0;
      words_q     <= '0;
      data_q      <= '0;
      en_q        <= 1'b0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else if (bus.i_abort && state_q != IDLE) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_acc) begin
            words_q <= '0;
            busy_q  <= 1'b1;
            if (num_sat == NUM_ZERO) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q     <= REQ;
              addr_q      <= bus.i_start_adrs;
              rd_adrs_q   <= bus.i_start_adrs;
              remaining_q <= num_sat;
              en_q        <= 1'b1;
            end
          end
        end
        REQ: begin
          en_q    <= 1'b0;
          state_q <= CAPT;
        end
        CAPT: begin
          data_q  <= bus.i_ram_data;
          valid_q <= 1'b1;
          last_q  <= (remaining_q == NUM_ONE);
          state_q <= SEND;
        end
        SEND: begin
          if (handshake) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            words_q <= words_q + NUM_ONE;
            if (remaining_q == NUM_ONE) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q     <= REQ;
              addr_q      <= addr_next;
              rd_adrs_q   <= addr_next;
              remaining_q <= remaining_q - NUM_ONE;
              en_q        <= 1'b1;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef RAM_LOG_READER_CHECKSUM_EN
  logic [RAM_WIDTH-1:0] sum_q;

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      sum_q <= '0;
    end else if (start_acc) begin
      sum_q <= '0;
    end else if (handshake) begin
      sum_q <= sum_q + data_q;
    end
  end

  assign bus.o_checksum = sum_q;
`else
  assign bus.o_checksum = '0;
`endif

  assign bus.o_ram_en_read   = en_q;
  assign bus.o_ram_read_adrs = rd_adrs_q;
  assign bus.o_data          = data_q;
  assign bus.o_valid         = valid_q;
  assign bus.o_last          = last_q;
  assign bus.o_busy          = busy_q;
  assign bus.o_done          = done_q;
  assign bus.o_words_sent    = words_q;
endmodule

// File: tb/tb_ram_log_reader.sv
// Self-checking bench for ram_log_reader: a RAM model feeds the reader and each burst
// is compared against the list of words the burst should deliver.
module tb_ram_log_reader;
  localparam int RAM_WIDTH = 32;
  localparam int RAM_DEPTH = 32768;
  localparam int ADDR_W    = 15;

  logic clk = 1'b0;
  logic i_reset;
  int   assertCount = 0;
  int   failCount   = 0;

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

  always #5 clk = ~clk;

  ram_log_reader_if #(.RAM_WIDTH(RAM_WIDTH), .RAM_DEPTH(RAM_DEPTH)) bus ();

  ram_log_reader #(.RAM_WIDTH(RAM_WIDTH), .RAM_DEPTH(RAM_DEPTH)) dut (
    .clk     (clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  // Synchronous-read RAM: data appears one cycle after the read enable.
  always @(posedge clk) begin
    if (bus.o_ram_en_read) bus.i_ram_data <= mem[bus.o_ram_read_adrs];
  end

  // Runs one burst and checks every accepted word, timing, address and completion status.
  task automatic run_burst(input string name, input logic [ADDR_W-1:0] adrs,
                           input logic [ADDR_W:0] num, input int readyPct,
                           input int holdFirst, input int abortAt, input bit pokeStart,
                           input bit abortWithStart, input bit checkTiming);
    logic [RAM_WIDTH-1:0] expq [$];
    logic [RAM_WIDTH-1:0] expSum;
    logic [RAM_WIDTH-1:0] prevData;
    bit   prevValid, prevAcc, finished, rdy;
    int   n, k, c, enCount, held, budget, expAdr;
    n = (int'(num) > RAM_DEPTH) ? RAM_DEPTH : int'(num);
    expq.delete();
    expSum = '0;
    for (int i = 0; i < n; i++) begin
      expq.push_back(mem[(int'(adrs) + i) % RAM_DEPTH]);
      expSum = expSum + mem[(int'(adrs) + i) % RAM_DEPTH];
    end
`ifndef RAM_LOG_READER_CHECKSUM_EN
    expSum = '0;
`endif
    k = 0; enCount = 0; held = 0; finished = 0; prevValid = 0; prevAcc = 0; prevData = '0;
    budget = 40 * n + 40 + holdFirst;

    @(negedge clk);
    bus.i_start = 1'b1; bus.i_start_adrs = adrs; bus.i_num_words = num;
    bus.i_abort = abortWithStart; bus.i_ready = 1'b0;
    @(negedge clk);
    bus.i_start = 1'b0; bus.i_abort = 1'b0;

    for (c = 0; c < budget && !finished; c++) begin
      if (bus.o_done) begin
        finished = 1;
      end else begin
        assertCount++;
        if (bus.o_busy !== 1'b1) begin
          failCount++; $display("[TB] FAIL %s busy: got %b expected 1", name, bus.o_busy);
        end
        if (bus.o_ram_en_read) begin
          enCount++;
          expAdr = (int'(adrs) + k) % RAM_DEPTH;
          assertCount++;
          if (bus.o_ram_read_adrs !== ADDR_W'(expAdr) || bus.o_valid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL %s read_adrs: got %h valid %b expected %h valid 0",
                     name, bus.o_ram_read_adrs, bus.o_valid, expAdr);
          end
        end
        if (prevValid && !prevAcc) begin
          assertCount++;
          if (bus.o_valid !== 1'b1 || bus.o_data !== prevData) begin
            failCount++;
            $display("[TB] FAIL %s hold: got valid %b data %h expected valid 1 data %h",
                     name, bus.o_valid, bus.o_data, prevData);
          end
        end
        if (checkTiming && bus.o_valid && !prevValid) begin
          assertCount++;
          if (c !== 2 + 3 * k) begin
            failCount++;
            $display("[TB] FAIL %s valid_timing: got cycle %0d expected %0d", name, c, 2 + 3 * k);
          end
        end
        bus.i_start = (pokeStart && c == 1);
        if (pokeStart && c == 1) begin
          bus.i_start_adrs = ~adrs; bus.i_num_words = 1;
        end
        rdy = ($urandom_range(0, 99) < readyPct);
        if (bus.o_valid && k == 0 && held < holdFirst) begin
          rdy = 0; held++;
        end
        if (abortAt >= 0 && k == abortAt && bus.o_valid) begin
          bus.i_abort = 1'b1; bus.i_ready = 1'b1;
          @(negedge clk);
          bus.i_abort = 1'b0; bus.i_ready = 1'b0;
          assertCount++;
          if (bus.o_busy !== 1'b0 || bus.o_valid !== 1'b0 || bus.o_done !== 1'b0 ||
              bus.o_words_sent !== 16'(k)) begin
            failCount++;
            $display("[TB] FAIL %s abort: got busy %b valid %b done %b sent %0d expected 0 0 0 %0d",
                     name, bus.o_busy, bus.o_valid, bus.o_done, bus.o_words_sent, k);
          end
          @(negedge clk);
          assertCount++;
          if (bus.o_done !== 1'b0 || bus.o_ram_en_read !== 1'b0 || bus.o_busy !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL %s after_abort: got done %b en %b busy %b expected 0 0 0",
                     name, bus.o_done, bus.o_ram_en_read, bus.o_busy);
          end
          return;
        end
        bus.i_ready = rdy;
        prevAcc = bus.o_valid && rdy;
        if (prevAcc) begin
          assertCount++;
          if (k >= n) begin
            failCount++; $display("[TB] FAIL %s extra_word: got word %0d expected only %0d", name, k, n);
          end else if (bus.o_data !== expq[k] || bus.o_last !== (k == n - 1)) begin
            failCount++;
            $display("[TB] FAIL %s word%0d: got data %h last %b expected data %h last %b",
                     name, k, bus.o_data, bus.o_last, expq[k], (k == n - 1));
          end
          k++;
        end
        prevValid = bus.o_valid;
        prevData  = bus.o_data;
        @(negedge clk);
      end
    end
    bus.i_ready = 1'b0;

    assertCount++;
    if (!finished) begin
      failCount++; $display("[TB] FAIL %s timeout: got no o_done expected o_done within %0d cycles", name, budget);
    end else if (k !== n || bus.o_words_sent !== 16'(n) || enCount !== n) begin
      failCount++;
      $display("[TB] FAIL %s count: got accepted %0d sent %0d reads %0d expected %0d",
               name, k, bus.o_words_sent, enCount, n);
    end
    assertCount++;
    if (bus.o_checksum !== expSum) begin
      failCount++; $display("[TB] FAIL %s checksum: got %h expected %h", name, bus.o_checksum, expSum);
    end
    @(negedge clk);
    assertCount++;
    if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_words_sent !== 16'(n)) begin
      failCount++;
      $display("[TB] FAIL %s post_done: got done %b busy %b sent %0d expected 0 0 %0d",
               name, bus.o_done, bus.o_busy, bus.o_words_sent, n);
    end
  endtask

  task automatic test_reset();
    int w;
    i_reset = 1'b1;
    repeat (3) @(negedge clk);
    assertCount++;
    if ({bus.o_ram_en_read, bus.o_ram_read_adrs, bus.o_data, bus.o_valid, bus.o_last,
         bus.o_busy, bus.o_done, bus.o_words_sent, bus.o_checksum} !== '0) begin
      failCount++; $display("[TB] FAIL reset_state: got nonzero outputs expected all 0");
    end
    i_reset = 1'b0;
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_start_adrs = 15'h0005; bus.i_num_words = 3; bus.i_ready = 1'b0;
    @(negedge clk);
    bus.i_start = 1'b0;
    w = 0;
    while (!bus.o_valid && w < 20) begin
      @(negedge clk); w++;
    end
    assertCount++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== 32'h5) begin
      failCount++; $display("[TB] FAIL pre_reset_send: got valid %b data %h expected 1 00000005", bus.o_valid, bus.o_data);
    end
    #2 i_reset = 1'b1;
    #1;
    assertCount++;
    if ({bus.o_ram_en_read, bus.o_ram_read_adrs, bus.o_data, bus.o_valid, bus.o_last,
         bus.o_busy, bus.o_done, bus.o_words_sent, bus.o_checksum} !== '0) begin
      failCount++; $display("[TB] FAIL async_reset: got valid %b data %h busy %b expected all 0",
                            bus.o_valid, bus.o_data, bus.o_busy);
    end
    @(negedge clk);
    i_reset = 1'b0;
    run_burst("after_reset", 15'h0020, 2, 100, 0, -1, 0, 0, 1);
  endtask

  task automatic test_basic();
    run_burst("basic", 15'h0010, 4, 100, 0, -1, 0, 0, 1);
  endtask

  task automatic test_wrap();
    run_burst("wrap", 15'h7FFE, 3, 100, 0, -1, 0, 1, 1);
  endtask

  task automatic test_backpressure();
    run_burst("backpressure", 15'h0200, 2, 100, 10, -1, 0, 0, 0);
  endtask

  task automatic test_abort();
    run_burst("abort", 15'h0300, 5, 100, 0, 1, 1, 0, 0);
    run_burst("after_abort", 15'h0400, 2, 100, 0, -1, 0, 0, 1);
  endtask

  task automatic test_zero();
    run_burst("zero_words", 15'h0500, 0, 100, 0, -1, 0, 0, 0);
  endtask

  task automatic test_checksum();
    mem[15'h0100] = 32'hFFFF_FFFF;
    mem[15'h0101] = 32'h0000_0002;
    run_burst("checksum", 15'h0100, 2, 100, 0, -1, 0, 0, 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < RAM_DEPTH; i++) mem[i] = $urandom;
    for (int b = 0; b < 10; b++) begin
      run_burst("random", ADDR_W'($urandom_range(0, RAM_DEPTH - 1)),
                16'($urandom_range(0, 10)), $urandom_range(30, 100), 0,
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1,
                1'($urandom_range(0, 1)), 0, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < RAM_DEPTH; i++) mem[i] = 32'(i);
    bus.i_start = 1'b0; bus.i_start_adrs = '0; bus.i_num_words = '0;
    bus.i_abort = 1'b0; bus.i_ready = 1'b0; bus.i_ram_data = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_abort();
    test_zero();
    test_checksum();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
